mul_booth_seq: RTL

- Multi-cycle controller that sequences the radix-4 Booth partial-product generator for MULT/MULTU in the CPU execute stage.
- Accepts one 32x32 operation via valid/ready, iterates Booth digits into a 64-bit accumulator, and presents a {hi,lo} result held until consumed.
- Supports a synchronous flush for exception/branch cancel.

---
 rtl/mul_booth_seq_if.sv | 43 ++++
 rtl/mul_booth_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mul_booth_seq_if.sv
// Request/result bundle between the execute stage and the Booth multiplier sequencer.
// No storage; pure wiring.
// Handshake: in_valid/in_ready for operands, out_valid/out_ready for the {hi,lo} result.
interface mul_booth_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_hi;
    logic [31:0] out_lo;

    // Requester side (execute stage / bench)
    modport master (
        output in_valid,
        output in_signed,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  busy,
        input  out_valid,
        input  out_hi,
        input  out_lo
    );

    // Multiplier side
    modport slave (
        input  in_valid,
        input  in_signed,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output busy,
        output out_valid,
        output out_hi,
        output out_lo
    );
endinterface

// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth 32x32 multiplier (MULT/MULTU), 64-bit {hi,lo} result.
// Latency: result visible ceil(17/STEPS_PER_CYCLE) cycles after the accept edge; data-dependent
// (>=1 cycle) when MUL_EARLY_TERM_EN is defined. Backpressure: result held in DONE until out_ready, in_ready only in IDLE.
module mul_booth_seq #(
    // Booth digits retired per RUN cycle; only 1 or 2 are meaningful.
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    mul_booth_seq_if.slave  bus
);

    localparam int NUM_DIGITS = 17;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [63:0] r_x;      // multiplicand, extended to 64 bits
    logic [33:0] r_m;      // multiplier, extended to 34 bits so digit 16 sees the sign
    logic [63:0] r_acc;
    logic [4:0]  r_i;      // index of the next Booth digit to execute

    logic [34:0] w_m_ext;  // multiplier with the implicit M[-1]=0 appended at bit 0
    logic [63:0] w_acc_next;
    logic [4:0]  w_last_j;
    logic        w_last_digit;
    logic        w_run_done;
`ifdef MUL_EARLY_TERM_EN
    logic [33:0] w_m_tail;
    logic        w_early;
`endif

    // One Booth digit's contribution to the accumulator. Negative multiples are
    // formed as one's complement plus a carry-in of one, folded into the term.
    function automatic logic [63:0] booth_term(
        input logic [63:0] x,
        input logic [34:0] m_ext,
        input logic [4:0]  k
    );
        logic [63:0] xs;
        logic [34:0] msh;
        logic [2:0]  y;
        logic [63:0] t;
        xs  = x << {k, 1'b0};
        msh = m_ext >> {k, 1'b0};
        y   = msh[2:0];
        case (y)
            3'b001, 3'b010: t = xs;
            3'b011:         t = xs << 1;
            3'b100:         t = ~(xs << 1) + 64'd1;
            3'b101, 3'b110: t = ~xs + 64'd1;
            default:        t = 64'd0;
        endcase
        return t;
    endfunction

    // Accumulate this cycle's digits; digits past 16 do not exist and are skipped.
    always_comb begin
        w_m_ext    = {r_m, 1'b0};
        w_acc_next = r_acc;
        w_last_j   = r_i;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            if (int'(r_i) + s < NUM_DIGITS) begin
                w_acc_next = w_acc_next + booth_term(r_x, w_m_ext, r_i + 5'(s));
                w_last_j   = r_i + 5'(s);
            end
        end
        w_last_digit = (int'(w_last_j) == NUM_DIGITS - 1);
    end

`ifdef MUL_EARLY_TERM_EN
    // Remaining digits are all zero when M above the last consumed bit is a pure sign run.
    always_comb begin
        w_m_tail   = 34'($signed(r_m) >>> {w_last_j, 1'b1});
        w_early    = (w_m_tail == '0) || (w_m_tail == '1);
        w_run_done = w_last_digit || w_early;
    end
`else
    // Fixed latency: RUN ends only once digit 16 has been executed.
    always_comb begin
        w_run_done = w_last_digit;
    end
`endif

    // Control FSM and datapath registers; flush outranks accept, step and drain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_i     <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_i     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.in_signed ? {{32{bus.in_a[31]}}, bus.in_a}
                                                 : {32'd0, bus.in_a};
                        r_m     <= bus.in_signed ? {{2{bus.in_b[31]}}, bus.in_b}
                                                 : {2'b00, bus.in_b};
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_i   <= r_i + 5'(STEPS_PER_CYCLE);
                    if (w_run_done) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and result outputs are pure decodes of registered state.
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.out_hi    = r_acc[63:32];
        bus.out_lo    = r_acc[31:0];
    end

endmodule
